// File: rtl/pipe_pkg.sv
// Shared constants for the handshaked pipeline-stage register.
//   SKID_NONE / SKID_ON : values for the SKID parameter of pipe_stage_hs
//   CTRL_W_DEFAULT      : default width of the low-order control field
//                         (rf_writeEn, mem_writeEn, halt, J, ... are packed
//                         at the low bits of the payload by stage wrappers)
package pipe_pkg;

   localparam int unsigned SKID_NONE      = 0;
   localparam int unsigned SKID_ON        = 1;
   localparam int unsigned CTRL_W_DEFAULT = 8;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating cycle counter with synchronous clear.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   inc  : count this cycle
//   clr  : synchronous clear, wins over inc
//   cnt  : counter value, sticks at all-ones
module pipe_stall_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// Parametrised pipeline-stage register with valid/ready handshake.
//   clk, rst             : clock (rising edge), async active-low reset
//   in_valid/in_ready    : upstream handshake, in_data is the payload
//   out_valid/out_ready  : downstream handshake, out_data is the payload
//                          with payload[CTRL_W-1:0] forced to 0 when empty
//   flush                : synchronous kill of every held entry
//   cnt_clr              : synchronous clear of stall_cnt
//   stall_cnt            : saturating count of out_valid & ~out_ready cycles
// SKID=SKID_NONE : one entry, in_ready combinational from out_ready.
// SKID=SKID_ON   : main + skid entry, in_ready registered.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
   parameter int unsigned SKID   = SKID_NONE,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             main_v;
   logic [WIDTH-1:0] main_d;

   generate
      if (SKID == SKID_ON) begin : g_skid
         logic             skid_v, skid_v_n;
         logic [WIDTH-1:0] skid_d, skid_d_n;
         logic             main_v_n;
         logic [WIDTH-1:0] main_d_n;
         logic             rdy_q;
         logic             in_fire;

         assign in_fire  = in_valid & rdy_q;
         assign in_ready = rdy_q;

         // Skid only ever fills while main is stalled, so it always holds
         // the younger payload; main refills from skid first to keep order.
         always_comb begin
            main_v_n = main_v;
            main_d_n = main_d;
            skid_v_n = skid_v;
            skid_d_n = skid_d;
            if (flush) begin
               main_v_n = 1'b0;
               skid_v_n = 1'b0;
            end else if (!main_v || out_ready) begin
               if (skid_v) begin
                  main_v_n = 1'b1;
                  main_d_n = skid_d;
                  skid_v_n = in_fire;
                  if (in_fire) skid_d_n = in_data;
               end else begin
                  main_v_n = in_fire;
                  if (in_fire) main_d_n = in_data;
               end
            end else if (in_fire) begin
               skid_v_n = 1'b1;
               skid_d_n = in_data;
            end
         end

         // rdy_q resets low and rises on the first edge after release.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               main_v <= 1'b0;
               main_d <= '0;
               skid_v <= 1'b0;
               skid_d <= '0;
               rdy_q  <= 1'b0;
            end else begin
               main_v <= main_v_n;
               main_d <= main_d_n;
               skid_v <= skid_v_n;
               skid_d <= skid_d_n;
               rdy_q  <= ~skid_v_n;
            end
         end
      end else begin : g_single
         assign in_ready = ~main_v | out_ready;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               main_v <= 1'b0;
               main_d <= '0;
            end else if (flush) begin
               main_v <= 1'b0;
            end else if (in_ready) begin
               main_v <= in_valid;
               if (in_valid) main_d <= in_data;
            end
         end
      end
   endgenerate

   assign out_valid = main_v;

   // Bubble masking: an empty stage never drives a control bit downstream.
   always_comb begin
      out_data = main_d;
      if (!main_v) out_data[CTRL_W-1:0] = '0;
   end

   pipe_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (main_v & ~out_ready),
      .clr (cnt_clr),
      .cnt (stall_cnt)
   );

endmodule
